soc_system_input_pio_irq: RTL and testbench

Parametrised Avalon-MM input PIO, successor to the 2-bit button PIO. Adds:
- configurable width
- input synchronisers and per-bit debounce
- per-bit rising/falling edge select
- write-1-to-clear edge capture
- maskable level interrupt to the HPS interrupt controller

Sits on the lightweight HPS-to-FPGA bridge beside the other soc_system PIOs.

---
 rtl/soc_system_pio_pkg.sv | 22 ++
 rtl/soc_system_pio_debounce.sv | 60 ++++++
 rtl/soc_system_input_pio_irq.sv | 110 +++++++++++
 tb/tb_soc_system_input_pio_irq.sv | 268 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/soc_system_pio_pkg.sv
// Shared definitions for the soc_system input PIO: register word addresses and
// the width helper used to size the debounce counters.
package soc_system_pio_pkg;

  localparam logic [2:0] ADDR_DATA = 3'd0;
  localparam logic [2:0] ADDR_RAW  = 3'd1;
  localparam logic [2:0] ADDR_MASK = 3'd2;
  localparam logic [2:0] ADDR_EDGE = 3'd3;
  localparam logic [2:0] ADDR_RISE = 3'd4;
  localparam logic [2:0] ADDR_FALL = 3'd5;
  localparam logic [2:0] ADDR_CTRL = 3'd6;

  // Ceiling log2, never below 1 so a counter always has at least one bit.
  function automatic int clog2(input int value);
    int bits;
    bits = 0;
    for (int v = value - 1; v > 0; v = v >> 1) bits++;
    if (bits == 0) bits = 1;
    return bits;
  endfunction

endpackage

// File: rtl/soc_system_pio_debounce.sv
// Single-bit input conditioner: a synchroniser chain followed by a stability
// counter that only accepts a new level after DEBOUNCE_CYCLES identical samples.
module soc_system_pio_debounce
  import soc_system_pio_pkg::*;
#(
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 50000
) (
  input  logic clk,
  input  logic reset,
  input  logic en,
  input  logic in,
  output logic s,
  output logic q
);

  localparam int              CW       = clog2(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0]   CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic [CW-1:0]          cnt_q, cnt_d;
  logic                   deb_q, deb_d;

  assign s = sync_q[SYNC_STAGES-1];
  assign q = deb_q;

  // NOTE: every variable gets its hold value first so no path through the
  // block leaves it unassigned; that is what keeps this from becoming a latch.
  always_comb begin
    sync_d = {sync_q[SYNC_STAGES-2:0], in};
    cnt_d  = cnt_q;
    deb_d  = deb_q;
    if (!en) begin
      deb_d = s;
      cnt_d = '0;
    end else if (s == deb_q) begin
      cnt_d = '0;
    end else if (cnt_q == CNT_LAST) begin
      deb_d = s;
      cnt_d = '0;
    end else begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge value of its neighbours, which the synchroniser chain relies on.
  always_ff @(posedge clk) begin
    if (reset) begin
      sync_q <= '0;
      cnt_q  <= '0;
      deb_q  <= 1'b0;
    end else begin
      sync_q <= sync_d;
      cnt_q  <= cnt_d;
      deb_q  <= deb_d;
    end
  end

endmodule

// File: rtl/soc_system_input_pio_irq.sv
// Avalon-MM input PIO with per-bit debounce, selectable edge capture
// (write-1-to-clear) and a maskable level interrupt.
module soc_system_input_pio_irq
  import soc_system_pio_pkg::*;
#(
  parameter int WIDTH           = 4,
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 50000
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [2:0]       address,
  input  logic             chipselect,
  input  logic             write_n,
  input  logic [31:0]      writedata,
  output logic [31:0]      readdata,
  input  logic [WIDTH-1:0] in_port,
  output logic             irq
);

  logic [WIDTH-1:0] s_vec, q_vec;
  logic [WIDTH-1:0] prev_q, prev_d;
  logic [WIDTH-1:0] edge_q, edge_d;
  logic [WIDTH-1:0] mask_q, mask_d;
  logic [WIDTH-1:0] rise_en_q, rise_en_d;
  logic [WIDTH-1:0] fall_en_q, fall_en_d;
  logic             deb_en_q, deb_en_d;
  logic             irq_q, irq_d;
  logic [31:0]      rdata_q, rdata_d;
  logic [WIDTH-1:0] wdata, clr, ev;
  logic             strobe;
  logic             unused_wdata;

  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    soc_system_pio_debounce #(
      .SYNC_STAGES    (SYNC_STAGES),
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_debounce (
      .clk  (clk),
      .reset(reset),
      .en   (deb_en_q),
      .in   (in_port[i]),
      .s    (s_vec[i]),
      .q    (q_vec[i])
    );
  end

  assign strobe       = chipselect & ~write_n;
  assign wdata        = writedata[WIDTH-1:0];
  assign unused_wdata = ^writedata;
  assign readdata     = rdata_q;
  assign irq          = irq_q;

  always_comb begin
    mask_d    = mask_q;
    rise_en_d = rise_en_q;
    fall_en_d = fall_en_q;
    deb_en_d  = deb_en_q;
    if (strobe) begin
      case (address)
        ADDR_MASK: mask_d    = wdata;
        ADDR_RISE: rise_en_d = wdata;
        ADDR_FALL: fall_en_d = wdata;
        ADDR_CTRL: deb_en_d  = writedata[0];
        default:   ;
      endcase
    end

    // A clear and a fresh event on the same bit resolve in favour of the event.
    clr    = (strobe && address == ADDR_EDGE) ? wdata : '0;
    ev     = (q_vec & ~prev_q & rise_en_q) | (~q_vec & prev_q & fall_en_q);
    edge_d = (edge_q & ~clr) | ev;
    prev_d = q_vec;
    irq_d  = |(edge_d & mask_q);

    case (address)
      ADDR_DATA: rdata_d = 32'(q_vec);
      ADDR_RAW:  rdata_d = 32'(s_vec);
      ADDR_MASK: rdata_d = 32'(mask_q);
      ADDR_EDGE: rdata_d = 32'(edge_q);
      ADDR_RISE: rdata_d = 32'(rise_en_q);
      ADDR_FALL: rdata_d = 32'(fall_en_q);
      ADDR_CTRL: rdata_d = {31'd0, deb_en_q};
      default:   rdata_d = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      prev_q    <= '0;
      edge_q    <= '0;
      mask_q    <= '0;
      rise_en_q <= '0;
      fall_en_q <= '0;
      deb_en_q  <= 1'b1;
      irq_q     <= 1'b0;
      rdata_q   <= '0;
    end else begin
      prev_q    <= prev_d;
      edge_q    <= edge_d;
      mask_q    <= mask_d;
      rise_en_q <= rise_en_d;
      fall_en_q <= fall_en_d;
      deb_en_q  <= deb_en_d;
      irq_q     <= irq_d;
      rdata_q   <= rdata_d;
    end
  end

endmodule

// File: tb/tb_soc_system_input_pio_irq.sv
// Bench for the input PIO: directed scenarios plus random bus/input traffic,
// all compared each cycle against a behavioural model of the register file.
module tb_soc_system_input_pio_irq;

  localparam int W  = 4;
  localparam int SS = 2;
  localparam int DC = 8;

  logic          clk = 1'b0;
  logic          reset;
  logic [2:0]    address;
  logic          chipselect;
  logic          write_n;
  logic [31:0]   writedata;
  logic [31:0]   readdata;
  logic [W-1:0]  in_port;
  logic          irq;

  int errors = 0;
  int checks = 0;

  soc_system_input_pio_irq #(
    .WIDTH          (W),
    .SYNC_STAGES    (SS),
    .DEBOUNCE_CYCLES(DC)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .address   (address),
    .chipselect(chipselect),
    .write_n   (write_n),
    .writedata (writedata),
    .readdata  (readdata),
    .in_port   (in_port),
    .irq       (irq)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got running expected finished");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Reference model: register contents, an input-delay queue standing in for
  // the synchroniser, and a per-bit "cycles in disagreement" count.
  logic [W-1:0] m_s, m_q, m_prev, m_edge, m_mask, m_rise, m_fall;
  logic         m_deb, m_irq;
  logic [31:0]  m_rd;
  int           m_cnt[W];
  logic [W-1:0] m_hist[$];

  task automatic model_step();
    logic [W-1:0] s_new, q_new, ev, clr, edge_new;
    logic         wr;
    if (reset) begin
      m_s = '0; m_q = '0; m_prev = '0; m_edge = '0;
      m_mask = '0; m_rise = '0; m_fall = '0;
      m_deb = 1'b1; m_irq = 1'b0; m_rd = '0;
      for (int i = 0; i < W; i++) m_cnt[i] = 0;
      m_hist.delete();
      for (int i = 0; i < SS - 1; i++) m_hist.push_back('0);
      return;
    end
    case (address)
      3'd0: m_rd = 32'(m_q);
      3'd1: m_rd = 32'(m_s);
      3'd2: m_rd = 32'(m_mask);
      3'd3: m_rd = 32'(m_edge);
      3'd4: m_rd = 32'(m_rise);
      3'd5: m_rd = 32'(m_fall);
      3'd6: m_rd = {31'd0, m_deb};
      default: m_rd = 32'd0;
    endcase
    m_hist.push_back(in_port);
    s_new = m_hist.pop_front();
    q_new = m_q;
    for (int i = 0; i < W; i++) begin
      if (!m_deb) begin
        q_new[i] = m_s[i];
        m_cnt[i] = 0;
      end else if (m_s[i] == m_q[i]) begin
        m_cnt[i] = 0;
      end else if (m_cnt[i] == DC - 1) begin
        q_new[i] = m_s[i];
        m_cnt[i] = 0;
      end else begin
        m_cnt[i] = m_cnt[i] + 1;
      end
    end
    wr       = chipselect & ~write_n;
    ev       = (m_q & ~m_prev & m_rise) | (~m_q & m_prev & m_fall);
    clr      = (wr && address == 3'd3) ? writedata[W-1:0] : '0;
    edge_new = (m_edge & ~clr) | ev;
    m_irq    = |(edge_new & m_mask);
    m_edge   = edge_new;
    m_prev   = m_q;
    m_q      = q_new;
    m_s      = s_new;
    if (wr) begin
      if (address == 3'd2) m_mask = writedata[W-1:0];
      if (address == 3'd4) m_rise = writedata[W-1:0];
      if (address == 3'd5) m_fall = writedata[W-1:0];
      if (address == 3'd6) m_deb  = writedata[0];
    end
  endtask

  task automatic cycle(input logic [2:0] a, input logic cs, input logic wn, input logic [31:0] wd);
    address    = a;
    chipselect = cs;
    write_n    = wn;
    writedata  = wd;
    @(posedge clk);
    model_step();
    #1;
    check("irq_vs_model", irq, m_irq);
    check("readdata_vs_model", readdata, m_rd);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle(3'd7, 1'b0, 1'b1, 32'd0);
  endtask

  task automatic wr(input logic [2:0] a, input logic [31:0] d);
    cycle(a, 1'b1, 1'b0, d);
  endtask

  task automatic rd(input logic [2:0] a);
    cycle(a, 1'b1, 1'b1, 32'd0);
  endtask

  initial begin
    int n;
    reset      = 1'b1;
    address    = '0;
    chipselect = 1'b0;
    write_n    = 1'b1;
    writedata  = '0;
    in_port    = '0;
    idle(2);
    reset = 1'b0;

    for (int a = 0; a < 8; a++) begin
      rd(3'(a));
      check($sformatf("reset_read%0d", a), readdata, (a == 6) ? 32'd1 : 32'd0);
    end
    check("reset_irq", irq, 32'd0);

    // Short bounces on bit0 must never be accepted.
    for (int k = 0; k < 4; k++) begin
      in_port[0] = 1'b1; idle(3);
      in_port[0] = 1'b0; idle(3);
    end
    rd(3'd0);
    check("bounce_rejected", readdata, 32'd0);
    in_port[0] = 1'b1;
    idle(DC + SS - 1);
    rd(3'd0);
    check("deb_not_yet", readdata, 32'd0);
    rd(3'd0);
    check("deb_accepted", readdata, 32'd1);

    // Rising capture on bit0 with interrupt, then write-1-to-clear.
    wr(3'd4, 32'h1);
    wr(3'd2, 32'h1);
    in_port[0] = 1'b0;
    idle(DC + SS + 2);
    in_port[0] = 1'b1;
    n = 0;
    while (irq !== 1'b1 && n < 40) begin idle(1); n++; end
    check("rise_irq", irq, 32'd1);
    rd(3'd3);
    check("rise_edge", readdata, 32'h1);
    wr(3'd3, 32'h1);
    check("clear_irq", irq, 32'd0);
    rd(3'd3);
    check("clear_edge", readdata, 32'h0);

    // Falling-only capture on bit1.
    wr(3'd5, 32'h2);
    wr(3'd4, 32'h0);
    in_port[1] = 1'b1;
    idle(DC + SS + 3);
    rd(3'd3);
    check("fall_rise_ignored", readdata, 32'h0);
    in_port[1] = 1'b0;
    idle(DC + SS + 3);
    rd(3'd3);
    check("fall_edge", readdata, 32'h2);
    check("fall_irq_masked", irq, 32'd0);
    wr(3'd3, 32'h2);

    // Debounce off: clear coinciding with a new bit0 rising edge.
    wr(3'd6, 32'h0);
    wr(3'd5, 32'h0);
    wr(3'd4, 32'h1);
    wr(3'd2, 32'h1);
    in_port[0] = 1'b0; idle(5);
    in_port[0] = 1'b1; idle(5);
    check("coinc_pre_irq", irq, 32'd1);
    in_port[0] = 1'b0; idle(5);
    in_port[0] = 1'b1;
    n = 0;
    while (!(m_q[0] && !m_prev[0]) && n < 10) begin idle(1); n++; end
    check("coinc_event_pending", 32'(m_q[0] & ~m_prev[0]), 32'd1);
    wr(3'd3, 32'h1);
    check("coinc_irq", irq, 32'd1);
    rd(3'd3);
    check("coinc_edge", readdata, 32'h1);

    // Single-cycle pulse on bit2 with debounce bypassed, masked then unmasked.
    wr(3'd3, 32'hF);
    wr(3'd2, 32'h0);
    wr(3'd4, 32'h4);
    in_port[2] = 1'b1; idle(1);
    in_port[2] = 1'b0; idle(6);
    rd(3'd3);
    check("pulse_edge", readdata, 32'h4);
    check("pulse_irq_masked", irq, 32'd0);
    wr(3'd2, 32'h4);
    idle(1);
    check("unmask_irq", irq, 32'd1);
    wr(3'd2, 32'h0);
    idle(1);
    check("remask_irq", irq, 32'd0);
    rd(3'd3);
    check("mask_keeps_edge", readdata, 32'h4);

    // Ignored writes and truncated write data.
    wr(3'd7, 32'hFFFF_FFFF);
    wr(3'd0, 32'hFFFF_FFFF);
    wr(3'd1, 32'hFFFF_FFFF);
    rd(3'd7);
    check("addr7_reads_zero", readdata, 32'h0);
    wr(3'd2, 32'hFFFF_FFF0);
    rd(3'd2);
    check("mask_upper_ignored", readdata, 32'h0);
    wr(3'd2, 32'hFFFF_FFFF);
    rd(3'd2);
    check("mask_zero_extended", readdata, 32'hF);

    // Random bus traffic with slowly changing inputs.
    wr(3'd6, 32'h1);
    for (int k = 0; k < 800; k++) begin
      logic [2:0] a;
      logic       cs, wn;
      if ($urandom_range(0, 19) == 0) in_port = W'($urandom);
      a  = 3'($urandom_range(0, 7));
      cs = ($urandom_range(0, 3) != 0);
      wn = ($urandom_range(0, 3) != 0);
      if (a == 3'd6 && !wn) cycle(a, cs, wn, {31'd0, ($urandom_range(0, 3) != 0)});
      else                  cycle(a, cs, wn, $urandom);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
